// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the date/time setting controller: mode and field
// encodings, reset defaults and calendar helpers.
package time_set_ctrl_pkg;

    typedef enum logic [3:0] {
        MODE_RUN   = 4'd0,
        MODE_DATE  = 4'd1,
        MODE_TIME  = 4'd2,
        MODE_ALARM = 4'd3
    } mode_e;

    localparam logic [1:0] FLD_YEAR  = 2'd0;
    localparam logic [1:0] FLD_MONTH = 2'd1;
    localparam logic [1:0] FLD_DAY   = 2'd2;
    localparam logic [1:0] FLD_WEEK  = 2'd3;
    localparam logic [1:0] FLD_HOUR  = 2'd0;
    localparam logic [1:0] FLD_MIN   = 2'd1;
    localparam logic [1:0] FLD_SEC   = 2'd2;

    localparam logic [1:0] DATE_FLD_LAST = 2'd3;
    localparam logic [1:0] TIME_FLD_LAST = 2'd2;

    localparam logic [14:0] RST_YEAR  = 15'd2000;
    localparam logic [3:0]  RST_MONTH = 4'd1;
    localparam logic [4:0]  RST_DAY   = 5'd1;
    localparam logic [3:0]  RST_WEEK  = 4'd6;
    localparam logic [5:0]  RST_HOUR  = 6'd0;
    localparam logic [5:0]  RST_MIN   = 6'd0;
    localparam logic [5:0]  RST_SEC   = 6'd0;

    function automatic logic is_leap(input logic [14:0] year);
        return ((year % 15'd4) == 15'd0) &&
               (((year % 15'd100) != 15'd0) || ((year % 15'd400) == 15'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [14:0] year,
                                                 input logic [3:0]  month);
        logic [4:0] dim;
        case (month)
            4'd2:    dim = is_leap(year) ? 5'd29 : 5'd28;
            4'd4,
            4'd6,
            4'd9,
            4'd11:   dim = 5'd30;
            default: dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, level debouncer and a
// single-cycle press pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
        press_d = level_q & ~level_prev_q;
    end

    // Synchroniser, debounce state and press pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Five-button date/time setting controller: mode FSM, field selection and
// wrapping value arithmetic with day clamping on month/year edits.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int YEAR_MAX        = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        middle,
    output logic [3:0]  mode,
    output logic [14:0] year_d,
    output logic [3:0]  month_d,
    output logic [4:0]  day_d,
    output logic [5:0]  hour_d,
    output logic [5:0]  min_d,
    output logic [5:0]  sec_d,
    output logic [3:0]  week_s,
    output logic [1:0]  field,
    output logic        set_active
);

    localparam logic [14:0] YR_MAX = 15'(YEAR_MAX);

    logic up_p, down_p, left_p, right_p, mid_p;
    logic up_v, dn_v, lf_v, rt_v;

    mode_e       mode_q, mode_d;
    logic [1:0]  field_q, field_d;
    logic [1:0]  fld_last_s;
    logic [14:0] yr_q, yr_d;
    logic [3:0]  mon_q, mon_d;
    logic [4:0]  day_q, day_nx;
    logic [3:0]  wk_q, wk_d;
    logic [5:0]  hr_q, hr_d;
    logic [5:0]  mn_q, mn_d;
    logic [5:0]  sc_q, sc_d;
    logic        act_q, act_d;
    logic [4:0]  dim_s;
    logic [4:0]  new_dim_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up
        (.clk(clk), .rst(rst), .btn(up),     .press(up_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down
        (.clk(clk), .rst(rst), .btn(down),   .press(down_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left
        (.clk(clk), .rst(rst), .btn(left),   .press(left_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right
        (.clk(clk), .rst(rst), .btn(right),  .press(right_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mid
        (.clk(clk), .rst(rst), .btn(middle), .press(mid_p));

    // Opposing presses in the same cycle cancel each other.
    assign up_v = up_p & ~down_p;
    assign dn_v = down_p & ~up_p;
    assign rt_v = right_p & ~left_p;
    assign lf_v = left_p & ~right_p;

    // Next-state: mode stepping, value edits on the current field, field moves.
    always_comb begin
        mode_d     = mode_q;
        field_d    = field_q;
        yr_d       = yr_q;
        mon_d      = mon_q;
        day_nx     = day_q;
        wk_d       = wk_q;
        hr_d       = hr_q;
        mn_d       = mn_q;
        sc_d       = sc_q;
        dim_s      = days_in_month(yr_q, mon_q);
        new_dim_s  = dim_s;
        fld_last_s = (mode_q == MODE_DATE) ? DATE_FLD_LAST : TIME_FLD_LAST;

        if (mid_p) begin
            case (mode_q)
                MODE_RUN:   mode_d = MODE_DATE;
                MODE_DATE:  mode_d = MODE_TIME;
                MODE_TIME:  mode_d = MODE_ALARM;
                default:    mode_d = MODE_RUN;
            endcase
            field_d = 2'd0;
        end else if ((mode_q == MODE_DATE) || (mode_q == MODE_TIME)) begin
            if (up_v || dn_v) begin
                if (mode_q == MODE_DATE) begin
                    case (field_q)
                        FLD_YEAR:  yr_d = up_v ? ((yr_q == YR_MAX) ? 15'd0 : yr_q + 15'd1)
                                               : ((yr_q == 15'd0) ? YR_MAX : yr_q - 15'd1);
                        FLD_MONTH: mon_d = up_v ? ((mon_q >= 4'd12) ? 4'd1 : mon_q + 4'd1)
                                                : ((mon_q <= 4'd1) ? 4'd12 : mon_q - 4'd1);
                        FLD_DAY:   day_nx = up_v ? ((day_q >= dim_s) ? 5'd1 : day_q + 5'd1)
                                                 : ((day_q <= 5'd1) ? dim_s : day_q - 5'd1);
                        default:   wk_d = up_v ? ((wk_q >= 4'd7) ? 4'd1 : wk_q + 4'd1)
                                               : ((wk_q <= 4'd1) ? 4'd7 : wk_q - 4'd1);
                    endcase
                    // Month or year edits can shrink the month; keep the day legal.
                    new_dim_s = days_in_month(yr_d, mon_d);
                    if (day_nx > new_dim_s) begin
                        day_nx = new_dim_s;
                    end else begin
                        day_nx = day_nx;
                    end
                end else begin
                    case (field_q)
                        FLD_HOUR: hr_d = up_v ? ((hr_q >= 6'd23) ? 6'd0 : hr_q + 6'd1)
                                              : ((hr_q == 6'd0) ? 6'd23 : hr_q - 6'd1);
                        FLD_MIN:  mn_d = up_v ? ((mn_q >= 6'd59) ? 6'd0 : mn_q + 6'd1)
                                              : ((mn_q == 6'd0) ? 6'd59 : mn_q - 6'd1);
                        FLD_SEC:  sc_d = up_v ? ((sc_q >= 6'd59) ? 6'd0 : sc_q + 6'd1)
                                              : ((sc_q == 6'd0) ? 6'd59 : sc_q - 6'd1);
                        default:  sc_d = sc_q;
                    endcase
                end
            end else begin
                yr_d = yr_q;
            end

            if (rt_v) begin
                field_d = (field_q >= fld_last_s) ? 2'd0 : field_q + 2'd1;
            end else if (lf_v) begin
                field_d = (field_q == 2'd0) ? fld_last_s : field_q - 2'd1;
            end else begin
                field_d = field_q;
            end
        end else begin
            mode_d = mode_q;
        end

        act_d = (mode_d == MODE_DATE) || (mode_d == MODE_TIME);
    end

    // Mode FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_RUN;
            field_q <= 2'd0;
            yr_q    <= RST_YEAR;
            mon_q   <= RST_MONTH;
            day_q   <= RST_DAY;
            wk_q    <= RST_WEEK;
            hr_q    <= RST_HOUR;
            mn_q    <= RST_MIN;
            sc_q    <= RST_SEC;
            act_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            field_q <= field_d;
            yr_q    <= yr_d;
            mon_q   <= mon_d;
            day_q   <= day_nx;
            wk_q    <= wk_d;
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            sc_q    <= sc_d;
            act_q   <= act_d;
        end
    end

    assign mode       = mode_q;
    assign field      = field_q;
    assign year_d     = yr_q;
    assign month_d    = mon_q;
    assign day_d      = day_q;
    assign week_s     = wk_q;
    assign hour_d     = hr_q;
    assign min_d      = mn_q;
    assign sec_d      = sc_q;
    assign set_active = act_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a short debounce window.
module tb_time_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
    logic [3:0]  mode;
    logic [14:0] year_d;
    logic [3:0]  month_d;
    logic [4:0]  day_d;
    logic [5:0]  hour_d, min_d, sec_d;
    logic [3:0]  week_s;
    logic [1:0]  field;
    logic        set_active;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [4:0] B_MID = 5'b10000;
    localparam logic [4:0] B_UP  = 5'b01000;
    localparam logic [4:0] B_DN  = 5'b00100;
    localparam logic [4:0] B_LF  = 5'b00010;
    localparam logic [4:0] B_RT  = 5'b00001;

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .YEAR_MAX(9999)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .middle(middle), .mode(mode), .year_d(year_d), .month_d(month_d),
        .day_d(day_d), .hour_d(hour_d), .min_d(min_d), .sec_d(sec_d),
        .week_s(week_s), .field(field), .set_active(set_active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] b);
        {middle, up, down, left, right} = b;
    endtask

    // Hold long enough to be accepted and acted on, then release fully.
    task automatic press(input logic [4:0] b);
        @(negedge clk);
        drive(b);
        repeat (10) @(negedge clk);
        drive(5'b00000);
        repeat (10) @(negedge clk);
    endtask

    task automatic press_n(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_mode"},  32'(mode),       32'd0);
        check_eq({tag, "_field"}, 32'(field),      32'd0);
        check_eq({tag, "_year"},  32'(year_d),     32'd2000);
        check_eq({tag, "_month"}, 32'(month_d),    32'd1);
        check_eq({tag, "_day"},   32'(day_d),      32'd1);
        check_eq({tag, "_week"},  32'(week_s),     32'd6);
        check_eq({tag, "_hour"},  32'(hour_d),     32'd0);
        check_eq({tag, "_min"},   32'(min_d),      32'd0);
        check_eq({tag, "_sec"},   32'(sec_d),      32'd0);
        check_eq({tag, "_act"},   32'(set_active), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode cycling
        press(B_MID);
        check_eq("m1", 32'(mode), 32'd1);
        check_eq("m1_act", 32'(set_active), 32'd1);
        press(B_MID);
        check_eq("m2", 32'(mode), 32'd2);
        press(B_MID);
        check_eq("m3", 32'(mode), 32'd3);
        check_eq("m3_act", 32'(set_active), 32'd0);
        press(B_MID);
        check_eq("m0", 32'(mode), 32'd0);
        check_eq("m0_field", 32'(field), 32'd0);

        // Date editing, leap-year handling and day clamping
        press(B_MID);
        press_n(B_UP, 23);
        check_eq("year_2023", 32'(year_d), 32'd2023);
        press(B_RT);
        check_eq("fld_month", 32'(field), 32'd1);
        press(B_UP);
        check_eq("month_2", 32'(month_d), 32'd2);
        press(B_RT);
        press_n(B_UP, 27);
        check_eq("day_28", 32'(day_d), 32'd28);
        press(B_UP);
        check_eq("day_wrap_up", 32'(day_d), 32'd1);
        press(B_DN);
        check_eq("day_wrap_dn", 32'(day_d), 32'd28);
        press_n(B_LF, 2);
        press(B_UP);
        check_eq("year_2024", 32'(year_d), 32'd2024);
        press_n(B_RT, 2);
        press(B_UP);
        check_eq("day_29_leap", 32'(day_d), 32'd29);
        press_n(B_LF, 2);
        press(B_UP);
        check_eq("year_2025", 32'(year_d), 32'd2025);
        check_eq("day_clamp", 32'(day_d), 32'd28);
        press(B_LF);
        check_eq("fld_wrap_left", 32'(field), 32'd3);
        press_n(B_UP, 2);
        check_eq("week_wrap", 32'(week_s), 32'd1);
        press(B_RT);
        check_eq("fld_wrap_right", 32'(field), 32'd0);

        // Time editing
        press(B_MID);
        check_eq("time_mode", 32'(mode), 32'd2);
        check_eq("time_field0", 32'(field), 32'd0);
        press(B_DN);
        check_eq("hour_23", 32'(hour_d), 32'd23);
        press(B_UP);
        check_eq("hour_wrap", 32'(hour_d), 32'd0);
        press_n(B_RT, 3);
        check_eq("time_fld_wrap", 32'(field), 32'd0);
        press(B_LF);
        check_eq("time_fld_left", 32'(field), 32'd2);
        press(B_DN);
        check_eq("sec_59", 32'(sec_d), 32'd59);

        // Bounce then steady hold gives exactly one press
        @(negedge clk);
        drive(B_UP);
        repeat (2) @(negedge clk);
        drive(5'b00000);
        repeat (2) @(negedge clk);
        drive(B_UP);
        repeat (10) @(negedge clk);
        drive(5'b00000);
        repeat (10) @(negedge clk);
        check_eq("bounce_one", 32'(sec_d), 32'd0);

        // Simultaneous press arbitration
        press(B_UP | B_DN);
        check_eq("updn_ignored", 32'(sec_d), 32'd0);
        press(B_LF | B_RT);
        check_eq("lfrt_ignored", 32'(field), 32'd2);
        press(B_RT | B_UP);
        check_eq("val_old_field", 32'(sec_d), 32'd1);
        check_eq("fld_after_both", 32'(field), 32'd0);
        press(B_MID | B_UP);
        check_eq("mid_wins_mode", 32'(mode), 32'd3);
        check_eq("mid_wins_hour", 32'(hour_d), 32'd0);

        // Alarm mode ignores edit buttons
        press(B_UP);
        press(B_RT);
        check_eq("alarm_hour", 32'(hour_d), 32'd0);
        check_eq("alarm_field", 32'(field), 32'd0);
        check_eq("alarm_sec", 32'(sec_d), 32'd1);
        press(B_MID);
        check_eq("back_run", 32'(mode), 32'd0);

        // Reset in the middle of a time edit, with a button held across it
        press_n(B_MID, 2);
        press_n(B_UP, 15);
        check_eq("hour_15", 32'(hour_d), 32'd15);
        @(negedge clk);
        drive(B_UP);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (4) @(negedge clk);
        check_eq("rst_hold_hour", 32'(hour_d), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        drive(5'b00000);
        repeat (10) @(negedge clk);
        check_reset_vals("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
